// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns level-write requests into exclusive S/R pulses, then verifies latch feedback.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qn_fb,
  input  logic fault_clr,
  output logic done,
  output logic fault
);
  typedef enum logic [2:0] {IDLE, DRIVE, GAP, CHECK, FAULT} state_t;
  localparam logic [7:0] PW = 8'(PULSE_W - 1);
  localparam logic [7:0] GW = 8'(GAP_W - 1);
  state_t state;
  logic lvl;
  logic [7:0] cnt;
  // every output is assigned for the state being entered, so all of them are plain registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      lvl <= 1'b0;
      cnt <= 8'd0;
      s <= 1'b0;
      r <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            state <= DRIVE;
            lvl <= req_level;
            cnt <= PW;
            s <= req_level;
            r <= ~req_level;
            req_ready <= 1'b0;
          end else req_ready <= 1'b1;
        DRIVE:
          if (cnt == 8'd0) begin
            s <= 1'b0;
            r <= 1'b0;
            state <= (GAP_W > 0) ? GAP : CHECK;
            cnt <= GW;
          end else cnt <= cnt - 8'd1;
        GAP:
          if (cnt == 8'd0) state <= CHECK;
          else cnt <= cnt - 8'd1;
        CHECK:
          if (q_fb == lvl && qn_fb == ~lvl) begin
            state <= IDLE;
            done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            state <= FAULT;
            fault <= 1'b1;
          end
        FAULT:
          if (fault_clr) begin
            state <= IDLE;
            fault <= 1'b0;
            req_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed checks of three driver builds against a behavioural NOR latch.
module tb_sr_latch_driver;
  logic clk = 1'b0;
  logic [2:0] rst_n, req_valid, req_level, fault_clr, inj;
  logic [2:0] req_ready, s, r, done, fault, q, q_fb, qn_fb;
  int n_chk = 0;
  int n_fail = 0;
  logic mon = 1'b0;
  always #5 clk = ~clk;
  sr_latch_driver #(.PULSE_W(2), .GAP_W(1)) d0 (.clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]),
    .req_level(req_level[0]), .req_ready(req_ready[0]), .s(s[0]), .r(r[0]), .q_fb(q_fb[0]),
    .qn_fb(qn_fb[0]), .fault_clr(fault_clr[0]), .done(done[0]), .fault(fault[0]));
  sr_latch_driver #(.PULSE_W(1), .GAP_W(0)) d1 (.clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]),
    .req_level(req_level[1]), .req_ready(req_ready[1]), .s(s[1]), .r(r[1]), .q_fb(q_fb[1]),
    .qn_fb(qn_fb[1]), .fault_clr(fault_clr[1]), .done(done[1]), .fault(fault[1]));
  sr_latch_driver #(.PULSE_W(4), .GAP_W(1)) d2 (.clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]),
    .req_level(req_level[2]), .req_ready(req_ready[2]), .s(s[2]), .r(r[2]), .q_fb(q_fb[2]),
    .qn_fb(qn_fb[2]), .fault_clr(fault_clr[2]), .done(done[2]), .fault(fault[2]));
  // latch model; inj forces the illegal q=qn=0 feedback
  always @(posedge clk)
    for (int i = 0; i < 3; i++) q[i] <= s[i] ? 1'b1 : r[i] ? 1'b0 : q[i];
  assign q_fb = q & ~inj;
  assign qn_fb = ~q & ~inj;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [4:0] outs(input int i);
    return {s[i], r[i], done[i], fault[i], req_ready[i]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (mon)
      for (int i = 0; i < 3; i++) begin
        check("inv_sr", 5'(s[i] & r[i]), 5'd0);
        check("inv_df", 5'(done[i] & fault[i]), 5'd0);
        check("inv_drive", 5'((s[i] | r[i]) & (done[i] | fault[i] | req_ready[i])), 5'd0);
      end
  initial begin
    q = 3'b000;
    rst_n = 3'b000;
    req_valid = 3'b001;
    req_level = 3'b000;
    fault_clr = 3'b000;
    inj = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick;
      mon = 1'b1;
      check("reset_hold", outs(0), 5'b00000);
    end
    rst_n[0] = 1'b1;
    req_valid[0] = 1'b0;
    tick;
    check("reset_release", outs(0), 5'b00001);
    req_valid[0] = 1'b1;
    req_level[0] = 1'b1;
    tick;
    req_valid[0] = 1'b0;
    check("set_c1", outs(0), 5'b10000);
    tick;
    check("set_c2", outs(0), 5'b10000);
    tick;
    check("set_gap", outs(0), 5'b00000);
    tick;
    check("set_check", outs(0), 5'b00000);
    tick;
    check("set_done", outs(0), 5'b00101);
    tick;
    check("set_after", outs(0), 5'b00001);
    rst_n[1] = 1'b1;
    tick;
    check("b2b_release", outs(1), 5'b00001);
    req_valid[1] = 1'b1;
    req_level[1] = 1'b0;
    tick;
    req_valid[1] = 1'b0;
    check("b2b_r", outs(1), 5'b01000);
    tick;
    check("b2b_check", outs(1), 5'b00000);
    tick;
    check("b2b_done1", outs(1), 5'b00101);
    req_valid[1] = 1'b1;
    req_level[1] = 1'b1;
    tick;
    req_valid[1] = 1'b0;
    check("b2b_s", outs(1), 5'b10000);
    tick;
    check("b2b_check2", outs(1), 5'b00000);
    tick;
    check("b2b_done2", outs(1), 5'b00101);
    inj[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_level[0] = 1'b0;
    tick;
    req_valid[0] = 1'b0;
    check("flt_r", outs(0), 5'b01000);
    repeat (3) tick;
    check("flt_check", outs(0), 5'b00000);
    tick;
    check("flt_set", outs(0), 5'b00010);
    req_valid[0] = 1'b1;
    req_level[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("flt_sticky", outs(0), 5'b00010);
    end
    fault_clr[0] = 1'b1;
    tick;
    check("flt_clr", outs(0), 5'b00001);
    fault_clr[0] = 1'b0;
    req_valid[0] = 1'b0;
    inj[0] = 1'b0;
    tick;
    check("flt_idle", outs(0), 5'b00001);
    rst_n[2] = 1'b1;
    tick;
    check("mid_release", outs(2), 5'b00001);
    req_valid[2] = 1'b1;
    req_level[2] = 1'b1;
    tick;
    req_valid[2] = 1'b0;
    check("mid_c1", outs(2), 5'b10000);
    tick;
    check("mid_c2", outs(2), 5'b10000);
    rst_n[2] = 1'b0;
    tick;
    check("mid_reset", outs(2), 5'b00000);
    rst_n[2] = 1'b1;
    tick;
    check("mid_release2", outs(2), 5'b00001);
    req_valid[2] = 1'b1;
    req_level[2] = 1'b0;
    tick;
    req_valid[2] = 1'b0;
    check("mid_w_c1", outs(2), 5'b01000);
    repeat (3) tick;
    check("mid_w_c4", outs(2), 5'b01000);
    tick;
    check("mid_w_gap", outs(2), 5'b00000);
    tick;
    check("mid_w_check", outs(2), 5'b00000);
    tick;
    check("mid_w_done", outs(2), 5'b00101);
    for (int n = 0; n < 200; n++) begin
      int k = 0;
      while (!req_ready[0] && k < 12) begin
        tick;
        k++;
      end
      inj[0] = ($urandom_range(3) == 0);
      req_valid[0] = 1'b1;
      req_level[0] = 1'($urandom_range(1));
      tick;
      req_valid[0] = 1'b0;
      k = 0;
      while (!(done[0] | fault[0]) && k < 12) begin
        tick;
        k++;
      end
      check("sweep", {3'b000, done[0], fault[0]}, inj[0] ? 5'b00001 : 5'b00010);
      if (fault[0]) begin
        fault_clr[0] = 1'b1;
        tick;
        fault_clr[0] = 1'b0;
      end
      inj[0] = 1'b0;
    end
    tick;
    mon = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
